// File: rtl/alu_shift_pkg.sv
// Shared types for the sequential shift unit.
// Shift modes and controller states.
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSR,
    SH_LSL,
    SH_ASR,
    SH_ROR
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the multi-cycle shifter.
// Shifts data by k (1..STEP) and reports the last bit out.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int N    = 4,
  parameter int STEP = 1,
  parameter int SW   = $clog2(N) + 1
) (
  input  logic [N-1:0]  data,
  input  logic [SW-1:0] k,
  input  shift_op_t     op,
  output logic [N-1:0]  nxt,
  output logic          obit
);

  localparam logic [SW-1:0] NW     = SW'(N);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  logic [SW-1:0] kk;
  logic [SW-1:0] km1;
  logic [N-1:0]  lo;
  logic [N-1:0]  hi;

  // Shift by the clamped step and pick the bit that leaves the word.
  always_comb begin
    kk   = (k > STEP_W) ? STEP_W : k;
    km1  = kk - SW'(1);
    lo   = data >> km1;
    hi   = data << km1;
    nxt  = data;
    obit = lo[0];
    unique case (op)
      SH_LSR: nxt = data >> kk;
      SH_LSL: begin
        nxt  = data << kk;
        obit = hi[N-1];
      end
      SH_ASR: nxt = $signed(data) >>> kk;
      SH_ROR: nxt = (data >> kk) | (data << (NW - kk));
      default: nxt = data;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: LSR, LSL, ASR, ROR.
// Up to STEP bits per cycle, valid/ready on both sides.
module seq_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int N    = 4,
  parameter int STEP = 1,
  localparam int SW  = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  y,
  output logic          carry,
  output logic          zero
);

  localparam logic [SW-1:0] NW     = SW'(N);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  state_t        state_q, state_d;
  shift_op_t     op_q, op_d;
  logic [N-1:0]  data_q, data_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;

  logic [SW-1:0] amt;
  logic [SW-1:0] k;
  logic [N-1:0]  step_nxt;
  logic          step_obit;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign y         = data_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

  // Effective amount: rotate wraps, the others saturate at N.
  always_comb begin
    amt = (shamt > NW) ? NW : shamt;
    if (shift_op_t'(op) == SH_ROR) begin
      amt = shamt % NW;
    end
    k = (rem_q < STEP_W) ? rem_q : STEP_W;
  end

  shift_step #(
    .N    (N),
    .STEP (STEP),
    .SW   (SW)
  ) u_step (
    .data (data_q),
    .k    (k),
    .op   (op_q),
    .nxt  (step_nxt),
    .obit (step_obit)
  );

  // Controller: accept, iterate until rem is used up, hold result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = shift_op_t'(op);
          data_d  = a;
          rem_d   = amt;
          carry_d = 1'b0;
          if (amt == '0) begin
            state_d = S_DONE;
            zero_d  = (a == '0);
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d  = step_nxt;
        carry_d = step_obit;
        rem_d   = rem_q - k;
        if (rem_q == k) begin
          state_d = S_DONE;
          zero_d  = (step_nxt == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= SH_LSR;
      data_q  <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit (N=4, STEP=1 and STEP=2).
module tb_seq_shift_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid2;
  logic       in_ready, in_ready2;
  logic [3:0] a;
  logic [2:0] shamt;
  logic [1:0] op;
  logic       out_valid, out_valid2;
  logic       out_ready;
  logic [3:0] y, y2;
  logic       carry, carry2;
  logic       zero, zero2;

  int cmp  = 0;
  int mism = 0;
  int lat;

  always #5 clk = ~clk;

  seq_shift_unit #(.N(4), .STEP(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero)
  );

  seq_shift_unit #(.N(4), .STEP(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .y         (y2),
    .carry     (carry2),
    .zero      (zero2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input bit sel,
                       input logic [3:0] av,
                       input logic [2:0] sh,
                       input logic [1:0] o,
                       output int l);
    int w;
    w = 0;
    @(negedge clk);
    while (!(sel ? in_ready2 : in_ready) && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", sel ? in_ready2 : in_ready, 1);
    a     = av;
    shamt = sh;
    op    = o;
    if (sel) in_valid2 = 1'b1;
    else     in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    a     = ~av;
    shamt = 3'd5;
    op    = ~o;
    l = 1;
    while (!(sel ? out_valid2 : out_valid) && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic res(input string tag, input bit sel,
                     input int l, input int el,
                     input logic [3:0] ey,
                     input logic ec, input logic ez);
    chk({tag, "_lat"},   l, el);
    chk({tag, "_y"},     sel ? y2 : y, ey);
    chk({tag, "_carry"}, sel ? carry2 : carry, ec);
    chk({tag, "_zero"},  sel ? zero2 : zero, ez);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    shamt     = '0;
    op        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_ready2", in_ready2, 1);

    do_op(0, 4'b1011, 3'd1, 2'b00, lat);
    res("lsr1", 0, lat, 2, 4'b0101, 1, 0);
    do_op(0, 4'b1101, 3'd2, 2'b00, lat);
    res("lsr2", 0, lat, 3, 4'b0011, 0, 0);
    do_op(0, 4'b1000, 3'd2, 2'b10, lat);
    res("asr2", 0, lat, 3, 4'b1110, 0, 0);
    do_op(0, 4'b0001, 3'd1, 2'b11, lat);
    res("ror1", 0, lat, 2, 4'b1000, 1, 0);
    do_op(0, 4'b1010, 3'd4, 2'b11, lat);
    res("ror4", 0, lat, 1, 4'b1010, 0, 0);
    do_op(0, 4'b1111, 3'd4, 2'b01, lat);
    res("lsl4", 0, lat, 5, 4'b0000, 1, 1);
    do_op(0, 4'b1010, 3'd7, 2'b10, lat);
    res("asr_clamp", 0, lat, 5, 4'b1111, 1, 0);
    do_op(0, 4'b0000, 3'd0, 2'b00, lat);
    res("lsr0", 0, lat, 1, 4'b0000, 0, 1);

    do_op(1, 4'b1111, 3'd3, 2'b00, lat);
    res("s2_lsr3", 1, lat, 3, 4'b0001, 1, 0);
    do_op(1, 4'b1000, 3'd4, 2'b10, lat);
    res("s2_asr4", 1, lat, 3, 4'b1111, 1, 0);

    out_ready = 1'b0;
    do_op(0, 4'b0110, 3'd1, 2'b00, lat);
    res("bp", 0, lat, 2, 4'b0011, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_y", y, 4'b0011);
      chk("bp_carry", carry, 0);
      chk("bp_zero", zero, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a         = 4'b0011;
    shamt     = 3'd1;
    op        = 2'b01;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_valid_low", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res("b2b", 0, lat, 2, 4'b0110, 0, 0);

    @(negedge clk);
    while (!in_ready) @(negedge clk);
    a        = 4'b1000;
    shamt    = 3'd3;
    op       = 2'b00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_carry", carry, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_back", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_pulse", out_valid, 0);
    end
    do_op(0, 4'b0100, 3'd1, 2'b00, lat);
    res("after_rst", 0, lat, 2, 4'b0010, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Parametrised, multi-cycle shift unit for the ALU datapath. It generalises the combinational logical right shifter.
- Supports four modes: logical right, logical left, arithmetic right and rotate right.
- Shifts up to STEP bits per clock, with valid/ready handshakes on input and output.
- Also produces carry (last bit shifted out) and zero flags.
- Sits beside the adder/logic units; the ALU top muxes its result when op class = shift.

Parameters:
- N, 4, operand/result width; N >= 2.
- STEP, 1, maximum bits shifted per cycle; 1 <= STEP <= N.
- SW, $clog2(N)+1, shift-amount width (derived localparam; holds 0..N).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- a  in  N  operand.
- shamt  in  SW  shift amount.
- op  in  2  mode: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  N  result.
- carry  out  1  last bit shifted/rotated out.
- zero  out  1  y == 0.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE, y=0, carry=0, zero=0, out_valid=0, rem=0.
- in_ready = (state==IDLE) && !rst, combinational.
- State IDLE:
  - Accept on in_valid && in_ready. Latch a, op.
  - Effective amount rem: for LSR/LSL/ASR, rem = min(shamt, N); for ROR, rem = shamt mod N.
  - Clear carry.
  - Next state: SHIFT if rem != 0, else DONE.
- State SHIFT:
  - Each cycle, shift data by k = min(STEP, rem) in mode op; rem -= k.
  - carry <= last bit leaving the operand in that step:
    - LSR/ASR/ROR: bit k-1 of the pre-step data.
    - LSL: bit N-k of the pre-step data.
  - Fill rules: LSR/LSL fill with 0; ASR fills with the sign bit; ROR wraps bit 0 into N-1.
  - When rem == k, go to DONE.
- State DONE:
  - out_valid=1; y, carry and zero are stable and registered.
  - Hold indefinitely while out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops the next cycle.
- No request overlap: in_ready=0 in SHIFT and DONE.
- Latency from the accept edge to out_valid high: 1 + ceil(rem/STEP) cycles.
  - rem=0 → 1 cycle, result = a, carry=0.
- Clamping: shamt >= N in LSR/LSL gives y=0. In ASR it gives y = all sign bits. Carry follows the clamped amount.
- zero is computed from the final y, registered on entry to DONE.
- Reset mid-operation: any state returns to IDLE on the next edge. Outputs return to reset values and the in-flight request is discarded, with no out_valid pulse.
- shamt and op are sampled only at accept; later changes are ignored.
- in_valid while busy is held by the producer; it is not dropped by the unit.

Decomposition:
- Package alu_shift_pkg:
  - typedef enum logic [1:0] shift_op_t {SH_LSR, SH_LSL, SH_ASR, SH_ROR}.
  - typedef enum state_t {S_IDLE, S_SHIFT, S_DONE}.
- Sub-module shift_step: combinational, parameters N and STEP; inputs data, k, op; outputs next data and the out-bit.
- seq_shift_unit holds the FSM, the rem counter and the output registers.

Test Plan (N=4, STEP=1 unless noted):
1. LSR, a=1011, shamt=1 → y=0101, carry=1, zero=0; out_valid 2 cycles after accept.
2. LSR a=1101 shamt=2 → y=0011, carry=0, latency 3; ASR a=1000 shamt=2 → y=1110, carry=0.
3. ROR a=0001 shamt=1 → y=1000, carry=1. ROR shamt=4 → y=a, carry=0, latency 1. LSL a=1111 shamt=4 → y=0000, carry=1, zero=1, latency 5.
4. STEP=2, LSR a=1111 shamt=3 → y=0001, carry=1, latency 3 (steps of 2 then 1).
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid → y/carry/zero stable, in_ready=0. Assert out_ready → in_ready=1 next cycle, and a back-to-back request is accepted.
6. Reset mid-op: LSR a=1000 shamt=3, assert rst in the 2nd SHIFT cycle → next cycle out_valid=0, y=0. After rst deasserts, in_ready=1, and a new request (a=0100, LSR 1) returns 0010.
